// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin owner of one spi_xcvr with per-requester slave selects and setup/hold guard timing
module spi_arbiter #(
  parameter int NREQ       = 3,
  parameter int SETUP_CLKS = 4,
  parameter int HOLD_CLKS  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   start,
  input  logic [NREQ*8-1:0] tx,
  input  logic [NREQ*8-1:0] conf,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [7:0]        rx,
  output logic [NREQ-1:0]   ss_n,
  output logic              x_start,
  output logic [7:0]        x_tx,
  output logic [7:0]        x_conf,
  input  logic [7:0]        x_rx,
  input  logic              x_done
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(((SETUP_CLKS > HOLD_CLKS) ? SETUP_CLKS : HOLD_CLKS) + 1);
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_READY, S_XFER, S_HOLD, S_GAP} state_t;
  state_t state, state_d;
  logic [IW-1:0] own, own_d, ptr, ptr_d, win;
  logic [CW-1:0] cnt, cnt_d;
  logic [NREQ-1:0] gnt_d, done_d, ss_n_d, own_oh, win_oh;
  logic [7:0] rx_d, x_tx_d, x_conf_d;
  logic x_start_d, launch, found;
  assign own_oh = {{(NREQ-1){1'b0}}, 1'b1} << own;
  assign win_oh = {{(NREQ-1){1'b0}}, 1'b1} << win;
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NREQ]) begin
        win = IW'((int'(ptr) + k) % NREQ);
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state;
    own_d = own;
    ptr_d = ptr;
    cnt_d = cnt;
    gnt_d = gnt;
    done_d = '0;
    rx_d = rx;
    ss_n_d = ss_n;
    x_start_d = 1'b0;
    x_tx_d = x_tx;
    x_conf_d = x_conf;
    launch = (|req) && (state == S_IDLE || (state == S_GAP && cnt == '0));
    if (launch) begin
      own_d = win;
      ss_n_d = ~win_oh;
      cnt_d = CW'(SETUP_CLKS - 1);
      state_d = S_SETUP;
    end else begin
      case (state)
        S_SETUP: begin
          if (cnt == '0) begin
            gnt_d = own_oh;
            state_d = S_READY;
          end else cnt_d = cnt - 1'b1;
        end
        S_READY: begin
          if (!req[own]) begin
            gnt_d = '0;
            cnt_d = CW'(HOLD_CLKS - 1);
            state_d = S_HOLD;
          end else if (start[own]) begin
            x_start_d = 1'b1;
            x_tx_d = tx[int'(own)*8 +: 8];
            x_conf_d = conf[int'(own)*8 +: 8];
            state_d = S_XFER;
          end
        end
        S_XFER: begin
          if (x_done) begin
            rx_d = x_rx;
            done_d = own_oh;
            if (req[own]) state_d = S_READY;
            else begin
              gnt_d = '0;
              cnt_d = CW'(HOLD_CLKS - 1);
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (cnt == '0) begin
            ss_n_d = '1;
            cnt_d = CW'(HOLD_CLKS - 1);
            ptr_d = (int'(own) == NREQ - 1) ? '0 : own + 1'b1;
            state_d = S_GAP;
          end else cnt_d = cnt - 1'b1;
        end
        S_GAP: begin
          if (cnt == '0) state_d = S_IDLE;
          else cnt_d = cnt - 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      own <= '0;
      ptr <= '0;
      cnt <= '0;
      gnt <= '0;
      done <= '0;
      rx <= '0;
      ss_n <= '1;
      x_start <= 1'b0;
      x_tx <= '0;
      x_conf <= '0;
    end else begin
      state <= state_d;
      own <= own_d;
      ptr <= ptr_d;
      cnt <= cnt_d;
      gnt <= gnt_d;
      done <= done_d;
      rx <= rx_d;
      ss_n <= ss_n_d;
      x_start <= x_start_d;
      x_tx <= x_tx_d;
      x_conf <= x_conf_d;
    end
  end
endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: randomized requesters and transceiver checked against a transaction-level arbiter model
module tb_spi_arbiter;
  localparam int N = 3, SU = 2, HD = 2;
  logic clk_i = 1'b0, rst_i = 1'b1;
  logic [N-1:0] req = '0, start = '0;
  logic [N*8-1:0] tx = '0, conf = '0;
  logic [N-1:0] gnt, done, ss_n;
  logic [7:0] rx, x_tx, x_conf;
  logic [7:0] x_rx = '0;
  logic x_start;
  logic x_done = 1'b0;
  int errs = 0, checks = 0;
  int c = 0, own = 0, ptr_m = 0, t_fall = -1000, t_rise = -1000, t_gfall = -2000, xd_cnt = 0;
  int rem [N];
  logic busy = 1'b0;
  logic [N-1:0] m_gnt = '0, m_ss = '1;
  logic [7:0] l_tx = '0, l_conf = '0, l_rx = '0;
  spi_arbiter #(.NREQ(N), .SETUP_CLKS(SU), .HOLD_CLKS(HD)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req(req), .start(start), .tx(tx), .conf(conf),
    .gnt(gnt), .done(done), .rx(rx), .ss_n(ss_n), .x_start(x_start), .x_tx(x_tx),
    .x_conf(x_conf), .x_rx(x_rx), .x_done(x_done)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, c, got, exp);
    end
  endtask
  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction
  function automatic int rr(input int p, input logic [N-1:0] r);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction
  task automatic tick(input bit rnd);
    logic acc, dn;
    logic [N-1:0] eg, es;
    @(negedge clk_i);
    c++;
    dn = 1'b0;
    if (rst_i) begin
      chk("rst_gnt", gnt, 0);
      chk("rst_done", done, 0);
      chk("rst_rx", rx, 0);
      chk("rst_ss_n", ss_n, {N{1'b1}});
      chk("rst_x_start", x_start, 0);
      chk("rst_x_tx", x_tx, 0);
      chk("rst_x_conf", x_conf, 0);
      m_gnt = '0; m_ss = '1; busy = 1'b0; ptr_m = 0; own = 0;
      t_fall = c - 1000; t_rise = c - 1000; t_gfall = c - 2000;
      l_tx = '0; l_conf = '0; l_rx = '0; xd_cnt = 0;
    end else begin
      acc = (m_gnt != '0) && !busy && req[own] && start[own];
      chk("x_start", x_start, acc);
      if (acc) begin
        l_tx = tx[own*8 +: 8];
        l_conf = conf[own*8 +: 8];
      end
      chk("x_tx", x_tx, l_tx);
      chk("x_conf", x_conf, l_conf);
      dn = busy && x_done;
      chk("done", done, dn ? oh(own) : '0);
      if (dn) l_rx = x_rx;
      chk("rx", rx, l_rx);
      if (m_gnt != '0) eg = (busy && !x_done) ? m_gnt : (req[own] ? oh(own) : '0);
      else eg = (m_ss != '1 && c - t_fall == SU) ? oh(own) : '0;
      if (m_gnt != '0 && eg == '0) t_gfall = c;
      busy = acc || (busy && !dn);
      if (m_ss == '1) begin
        if (req != '0 && c - t_rise >= HD) begin
          own = rr(ptr_m, req);
          es = ~oh(own);
          t_fall = c;
        end else es = '1;
      end else if (t_gfall > t_fall && c - t_gfall >= HD) begin
        es = '1;
        t_rise = c;
        ptr_m = (own + 1) % N;
      end else es = m_ss;
      chk("gnt", gnt, eg);
      chk("ss_n", ss_n, es);
      m_gnt = eg;
      m_ss = es;
    end
    rst_i = 1'b0;
    x_done = 1'b0;
    if (xd_cnt > 0) begin
      xd_cnt--;
      if (xd_cnt == 0) begin
        x_done = 1'b1;
        x_rx = 8'($urandom);
      end
    end else if (x_start) xd_cnt = $urandom_range(1, 4);
    else if ($urandom_range(0, 15) == 0) begin
      x_done = 1'b1;
      x_rx = 8'($urandom);
    end
    tx = (N*8)'($urandom);
    conf = (N*8)'($urandom);
    for (int i = 0; i < N; i++) begin
      if (dn && own == i && rem[i] > 0) rem[i]--;
      if (req[i] && rem[i] == 0) req[i] = 1'b0;
      if (rnd && own == i && req[i] && $urandom_range(0, 11) == 0) begin
        req[i] = 1'b0;
        rem[i] = 0;
      end
      if (own == i && m_gnt[i] && !busy && req[i] && (!rnd || $urandom_range(0, 3) != 0)) start[i] = 1'b1;
      else start[i] = ($urandom_range(0, 3) == 0);
      if (rnd && !req[i] && $urandom_range(0, 9) == 0) begin
        req[i] = 1'b1;
        rem[i] = $urandom_range(1, 4);
      end
    end
    if (rnd && busy && $urandom_range(0, 29) == 0) rst_i = 1'b1;
  endtask
  initial begin
    for (int i = 0; i < N; i++) rem[i] = 1;
    req = '1;
    for (int n = 0; n < 60; n++) tick(1'b0);
    rem[0] = 4;
    req = 3'b001;
    for (int n = 0; n < 80; n++) tick(1'b0);
    rem[2] = 3;
    req = 3'b100;
    for (int n = 0; n < 60; n++) tick(1'b0);
    for (int n = 0; n < 4000; n++) tick(1'b1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
